// File: rtl/mesi_snoop_bus_arbiter.sv
// Round-robin snoop-bus arbiter for the L1 cluster: grant, broadcast snoop, merge acks into one response.
// Optional SNOOP_TIMEOUT_EN adds a snoop watchdog and the resp_err output.
module mesi_snoop_bus_arbiter #(
  parameter int NUM_CACHE = 4,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32
`ifdef SNOOP_TIMEOUT_EN
  , parameter int SNOOP_TIMEOUT = 15
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CACHE-1:0]        req_valid,
  input  logic [2*NUM_CACHE-1:0]      req_cmd,
  input  logic [ADDR_W*NUM_CACHE-1:0] req_addr,
  output logic [NUM_CACHE-1:0]        req_ready,
  output logic                        snp_valid,
  output logic [1:0]                  snp_cmd,
  output logic [ADDR_W-1:0]           snp_addr,
  output logic [NUM_CACHE-1:0]        snp_src,
  input  logic [NUM_CACHE-1:0]        snp_ack,
  input  logic [NUM_CACHE-1:0]        snp_shared,
  input  logic [NUM_CACHE-1:0]        snp_dirty,
  input  logic [DATA_W*NUM_CACHE-1:0] snp_data,
  output logic [NUM_CACHE-1:0]        resp_valid,
  output logic                        resp_shared,
  output logic                        resp_dirty,
  output logic [DATA_W-1:0]           resp_data,
`ifdef SNOOP_TIMEOUT_EN
  output logic                        resp_err,
`endif
  output logic                        busy
);

  localparam int IW = (NUM_CACHE > 1) ? $clog2(NUM_CACHE) : 1;
  localparam logic [IW:0] NC = (IW+1)'(NUM_CACHE);

  typedef enum logic [1:0] {IDLE = 2'd0, SNOOP = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]        rr_ptr, win, win_q, idx;
  logic [IW:0]          sum;
  logic                 found, grant, ack_done, blocked, data_upd;
  logic [NUM_CACHE-1:0] elig, win_oh, ack_vec, ack_new, ack_all, new_dirty, dirty_vec, src_q;
  logic [1:0]           win_cmd, cmd_q;
  logic [ADDR_W-1:0]    win_addr, addr_q;
  logic                 shared_q, dirty_q, resp_en;
  logic [DATA_W-1:0]    data_q, data_sel;

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(SNOOP_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q, to_expire;
  assign to_expire = (cnt == CW'(SNOOP_TIMEOUT - 1));
`endif

  // First eligible requester at or after rr_ptr, wrapping modulo NUM_CACHE.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CACHE; i++)
      elig[i] = req_valid[i] && (req_cmd[2*i +: 2] != 2'b00);
    for (int k = 0; k < NUM_CACHE; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= NC) sum = sum - NC;
      idx = sum[IW-1:0];
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh = NUM_CACHE'(1) << win;

  always_comb begin
    win_cmd  = '0;
    win_addr = '0;
    for (int i = 0; i < NUM_CACHE; i++) begin
      if (win_oh[i]) begin
        win_cmd  = req_cmd[2*i +: 2];
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign grant     = (state == IDLE) && found && !rst;
  assign req_ready = grant ? win_oh : '0;

  // The originator bit is preset in ack_vec, so its own ack and flags never land here.
  assign ack_new   = (state == SNOOP) ? (snp_ack & ~ack_vec) : '0;
  assign ack_all   = ack_vec | ack_new;
  assign ack_done  = &ack_all;
  assign new_dirty = ack_new & snp_dirty;

  // A newly acked dirty cache takes the data slot unless a lower index already holds it.
  always_comb begin
    blocked  = 1'b0;
    data_upd = 1'b0;
    data_sel = '0;
    for (int i = 0; i < NUM_CACHE; i++) begin
      if (!blocked && new_dirty[i]) begin
        data_upd = 1'b1;
        data_sel = snp_data[i*DATA_W +: DATA_W];
      end
      blocked = blocked | dirty_vec[i] | new_dirty[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (found) state_nxt = SNOOP;
      SNOOP: begin
        if (ack_done) state_nxt = RESP;
`ifdef SNOOP_TIMEOUT_EN
        else if (to_expire) state_nxt = RESP;
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      ack_vec   <= '0;
      dirty_vec <= '0;
      shared_q  <= 1'b0;
      dirty_q   <= 1'b0;
      data_q    <= '0;
`ifdef SNOOP_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            cmd_q   <= win_cmd;
            addr_q  <= win_addr;
            src_q   <= win_oh;
            win_q   <= win;
            ack_vec <= win_oh;
`ifdef SNOOP_TIMEOUT_EN
            cnt     <= '0;
`endif
          end
        end
        SNOOP: begin
          ack_vec   <= ack_all;
          shared_q  <= shared_q | (|(ack_new & snp_shared));
          dirty_q   <= dirty_q | (|new_dirty);
          dirty_vec <= dirty_vec | new_dirty;
          if (data_upd) data_q <= data_sel;
`ifdef SNOOP_TIMEOUT_EN
          cnt <= cnt + 1'b1;
          if (!ack_done && to_expire) err_q <= 1'b1;
`endif
        end
        RESP: begin
          rr_ptr    <= (win_q == IW'(NUM_CACHE - 1)) ? '0 : win_q + 1'b1;
          ack_vec   <= '0;
          dirty_vec <= '0;
          shared_q  <= 1'b0;
          dirty_q   <= 1'b0;
          data_q    <= '0;
`ifdef SNOOP_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign snp_valid = (state == SNOOP);
  assign snp_cmd   = cmd_q;
  assign snp_addr  = addr_q;
  assign snp_src   = src_q;
  assign busy      = (state != IDLE);

`ifdef SNOOP_TIMEOUT_EN
  assign resp_en  = (state == RESP) && !err_q;
  assign resp_err = (state == RESP) && err_q;
`else
  assign resp_en  = (state == RESP);
`endif

  assign resp_valid  = (state == RESP) ? src_q : '0;
  assign resp_shared = resp_en & shared_q;
  assign resp_dirty  = resp_en & dirty_q;
  assign resp_data   = resp_en ? data_q : '0;

endmodule

// File: tb/tb_mesi_snoop_bus_arbiter.sv
// Scoreboard bench for mesi_snoop_bus_arbiter: directed transactions push expectations, a negedge monitor checks them.
module tb_mesi_snoop_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [7:0]   req_cmd = '0;
  logic [79:0]  req_addr = '0;
  logic [3:0]   req_ready;
  logic         snp_valid;
  logic [1:0]   snp_cmd;
  logic [19:0]  snp_addr;
  logic [3:0]   snp_src;
  logic [3:0]   snp_ack = '0;
  logic [3:0]   snp_shared = '0;
  logic [3:0]   snp_dirty = '0;
  logic [127:0] snp_data = '0;
  logic [3:0]   resp_valid;
  logic         resp_shared;
  logic         resp_dirty;
  logic [31:0]  resp_data;
  logic         busy;
`ifdef SNOOP_TIMEOUT_EN
  logic         resp_err;
`endif

  mesi_snoop_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr), .req_ready(req_ready),
    .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr), .snp_src(snp_src),
    .snp_ack(snp_ack), .snp_shared(snp_shared), .snp_dirty(snp_dirty), .snp_data(snp_data),
    .resp_valid(resp_valid), .resp_shared(resp_shared), .resp_dirty(resp_dirty),
    .resp_data(resp_data),
`ifdef SNOOP_TIMEOUT_EN
    .resp_err(resp_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] oh; int gap; } gexp_t;
  typedef struct { logic [1:0] cmd; logic [19:0] addr; logic [3:0] src; } sexp_t;
  typedef struct { logic [3:0] oh; logic sh; logic dt; logic err; logic [31:0] data; int lat; } rexp_t;

  gexp_t gq[$];
  sexp_t sq[$];
  rexp_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_grant = 0;
  logic prev_snp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_g(input logic [3:0] oh, input int gap);
    gexp_t g; g.oh = oh; g.gap = gap; gq.push_back(g);
  endtask

  task automatic push_s(input logic [1:0] cmd, input logic [19:0] addr, input logic [3:0] src);
    sexp_t s; s.cmd = cmd; s.addr = addr; s.src = src; sq.push_back(s);
  endtask

  task automatic push_r(input logic [3:0] oh, input logic sh, input logic dt, input logic err,
                        input logic [31:0] data, input int lat);
    rexp_t r; r.oh = oh; r.sh = sh; r.dt = dt; r.err = err; r.data = data; r.lat = lat;
    rq.push_back(r);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a grant, a new snoop or a response.
  always @(negedge clk) begin
    gexp_t g; sexp_t s; rexp_t r;
    if (req_ready != 4'b0) begin
      if (gq.size() == 0) chk("unexpected_grant", req_ready, 0);
      else begin
        g = gq.pop_front();
        chk("grant_onehot", req_ready, g.oh);
        if (g.gap != 0) chk("grant_spacing", cyc - last_grant, g.gap);
      end
      last_grant = cyc;
    end
    if (snp_valid && !prev_snp) begin
      if (sq.size() == 0) chk("unexpected_snoop", snp_src, 0);
      else begin
        s = sq.pop_front();
        chk("snp_cmd", snp_cmd, s.cmd);
        chk("snp_addr", snp_addr, s.addr);
        chk("snp_src", snp_src, s.src);
      end
    end
    prev_snp = snp_valid;
    if (resp_valid != 4'b0) begin
      if (rq.size() == 0) chk("unexpected_resp", resp_valid, 0);
      else begin
        r = rq.pop_front();
        chk("resp_valid", resp_valid, r.oh);
        chk("resp_shared", resp_shared, r.sh);
        chk("resp_dirty", resp_dirty, r.dt);
        chk("resp_data", resp_data, r.data);
        chk("resp_latency", cyc - last_grant, r.lat);
`ifdef SNOOP_TIMEOUT_EN
        chk("resp_err", resp_err, r.err);
`endif
      end
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      done = !busy;
    end
    chk("return_to_idle", busy, 0);
  endtask

  // Single requester transaction; ackc[i] is the SNOOP cycle (1..15) cache i acks in, 0 = never.
  task automatic run_txn(input int src, input logic [1:0] cmd, input logic [19:0] addr,
                         input logic [3:0] nullreq, input logic [3:0][3:0] ackc,
                         input logic [3:0] sh, input logic [3:0] dt, input logic [3:0][31:0] dat,
                         input logic esh, input logic edt, input logic eerr,
                         input logic [31:0] edata, input int lat);
    logic [3:0] oh, am;
    bit got = 0;
    oh = 4'b0001 << src;
    @(posedge clk); #1;
    push_g(oh, 0);
    push_s(cmd, addr, oh);
    push_r(oh, esh, edt, eerr, edata, lat);
    for (int i = 0; i < 4; i++) begin
      req_cmd[2*i +: 2]   = oh[i] ? cmd : 2'b00;
      req_addr[20*i +: 20] = oh[i] ? addr : 20'hFFFFF;
    end
    req_valid = oh | nullreq;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = (req_ready != 4'b0);
    end
    if (!got) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = '0;
    req_cmd = '0;
    snp_data = dat;
    for (int k = 1; k <= 15; k++) begin
      for (int i = 0; i < 4; i++) am[i] = (ackc[i] == 4'(k));
      snp_ack = am;
      snp_shared = sh & am;
      snp_dirty = dt & am;
      @(posedge clk); #1;
    end
    snp_ack = '0; snp_shared = '0; snp_dirty = '0; snp_data = '0;
    wait_idle();
  endtask

  // Continuous BusRd from every cache in mask, all caches acking every cycle; stops after n grants.
  task automatic stream(input logic [3:0] mask, input int n);
    int seen = 0;
    @(posedge clk); #1;
    snp_ack = 4'hF; snp_shared = '0; snp_dirty = '0; snp_data = '0;
    for (int i = 0; i < 4; i++) begin
      req_cmd[2*i +: 2]    = mask[i] ? 2'b01 : 2'b00;
      req_addr[20*i +: 20] = 20'(i * 256);
    end
    req_valid = mask;
    for (int t = 0; t < 40 * n && seen < n; t++) begin
      @(negedge clk);
      if (req_ready != 4'b0) seen++;
    end
    if (seen < n) chk("stream_grant_timeout", seen, n);
    @(posedge clk); #1;
    req_valid = '0;
    req_cmd = '0;
    wait_idle();
    snp_ack = '0;
  endtask

  initial begin
    // Reset state, with requests already pending that must not be accepted.
    req_valid = 4'hF;
    req_cmd = 8'b01010101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_snoop_outs", {snp_valid, snp_cmd, snp_addr, snp_src}, 0);
    chk("reset_resp_outs", {resp_valid, resp_shared, resp_dirty, resp_data}, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    req_cmd = '0;

    // All four request continuously: round robin 0,1,2,3,0, three cycles apart.
    push_g(4'b0001, 0); push_g(4'b0010, 3); push_g(4'b0100, 3); push_g(4'b1000, 3); push_g(4'b0001, 3);
    push_s(2'b01, 20'h00000, 4'b0001); push_s(2'b01, 20'h00100, 4'b0010);
    push_s(2'b01, 20'h00200, 4'b0100); push_s(2'b01, 20'h00300, 4'b1000);
    push_s(2'b01, 20'h00000, 4'b0001);
    push_r(4'b0001, 0, 0, 0, 0, 2); push_r(4'b0010, 0, 0, 0, 0, 2); push_r(4'b0100, 0, 0, 0, 0, 2);
    push_r(4'b1000, 0, 0, 0, 0, 2); push_r(4'b0001, 0, 0, 0, 0, 2);
    stream(4'hF, 5);

    // Cache1 BusRd, others ack in the first snoop cycle; cache0 raises a cmd-00 request alongside.
    run_txn(1, 2'b01, 20'h00A40, 4'b0001, {4'd1, 4'd1, 4'd0, 4'd1}, 4'b0000, 4'b0000,
            {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0, 1'b0, 32'h0, 2);

    // Cache0 BusRdX; cache2 flushes late; caches 2,3 present cmd-00 requests that must lose.
    run_txn(0, 2'b10, 20'h0BEEF, 4'b1100, {4'd1, 4'd3, 4'd1, 4'd0}, 4'b0010, 4'b0100,
            {32'h0, 32'hDEADBEEF, 32'h5A5A5A5A, 32'h0}, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 4);

    // Two dirty responders, the higher index first: the lower index still owns the data.
    run_txn(0, 2'b01, 20'h01234, 4'b0000, {4'd1, 4'd1, 4'd2, 4'd0}, 4'b1000, 4'b1010,
            {32'h33333333, 32'h22222222, 32'h11111111, 32'h0}, 1'b1, 1'b1, 1'b0, 32'h11111111, 3);

    // Cache2 BusUpgr; its own ack with shared/dirty flags must not contribute.
    run_txn(2, 2'b11, 20'h0FFFF, 4'b0000, {4'd2, 4'd1, 4'd1, 4'd1}, 4'b0110, 4'b0100,
            {32'h0, 32'hBAD0BAD0, 32'h0, 32'h0}, 1'b1, 1'b0, 1'b0, 32'h0, 3);

    // Reset mid-SNOOP: outputs clear at once, no response, round robin restarts at 0.
    @(posedge clk); #1;
    push_g(4'b0010, 0);
    push_s(2'b10, 20'h12345, 4'b0010);
    req_cmd = 8'b00001000;
    req_addr[39:20] = 20'h12345;
    req_valid = 4'b0010;
    begin
      bit got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = (req_ready != 4'b0);
      end
      if (!got) chk("grant_timeout_rst", 0, 1);
    end
    @(posedge clk); #1;
    req_valid = '0; req_cmd = '0;
    snp_ack = 4'b0001;
    @(posedge clk); #1;
    snp_ack = '0;
    rst = 1'b1;
    #1;
    chk("midrst_snoop_outs", {req_ready, snp_valid, snp_cmd, snp_addr, snp_src}, 0);
    chk("midrst_resp_outs", {resp_valid, resp_shared, resp_dirty, resp_data}, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    push_g(4'b0001, 0); push_g(4'b1000, 3);
    push_s(2'b01, 20'h00000, 4'b0001); push_s(2'b01, 20'h00300, 4'b1000);
    push_r(4'b0001, 0, 0, 0, 0, 2); push_r(4'b1000, 0, 0, 0, 0, 2);
    stream(4'b1001, 2);

`ifdef SNOOP_TIMEOUT_EN
    // Cache3 never acks: abort after the timeout with error and no data.
    run_txn(1, 2'b01, 20'h00777, 4'b0000, {4'd0, 4'd1, 4'd0, 4'd1}, 4'b0001, 4'b0001,
            {32'h0, 32'h0, 32'h0, 32'hCAFE0000}, 1'b0, 1'b0, 1'b1, 32'h0, 16);
`endif

    repeat (4) @(posedge clk);
    chk("grant_queue_drained", gq.size(), 0);
    chk("snoop_queue_drained", sq.size(), 0);
    chk("resp_queue_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
